// File: rtl/step_dir_decoder.sv
// ---------------------------------------------------------------------------
// step_dir_decoder
//
// Receive side of a STEP/DIR/nEN stepper link. The three pins are brought
// into the clk domain, each STEP pulse is checked for minimum high time and
// for DIR setup before its rising edge, accepted steps move a signed
// microstep position, and the spacing of accepted rising edges is measured.
//
// Ports
//   clk           system clock
//   reset_n       synchronous active-low reset
//   step_in       STEP pin (asynchronous)
//   dir_in        DIR pin (asynchronous), 0 = CW (+1), 1 = CCW (-1)
//   enable_n_in   nEN pin (asynchronous), low = motor enabled
//   clear_pos     zero the position (wins over a coincident step)
//   err_clear     clear the sticky error flags (a coincident new error wins)
//   position      signed microstep position, wraps modulo 2^POS_WIDTH
//   step_strobe   one-cycle pulse per accepted step
//   step_dir      direction of the last accepted step
//   step_period   cycles between the last two accepted STEP rising edges
//   period_valid  step_period holds a real measurement
//   pulse_err     sticky: a STEP pulse was too short
//   setup_err     sticky: DIR moved too close before a STEP rising edge
// ---------------------------------------------------------------------------
module step_dir_decoder #(
   parameter int CLK_FREQ_HZ      = 50_000_000,
   parameter int MIN_PULSE_CYCLES = 50,
   parameter int DIR_SETUP_CYCLES = 10,
   parameter int POS_WIDTH        = 32,
   parameter int PERIOD_WIDTH     = 24
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           step_in,
   input  logic                           dir_in,
   input  logic                           enable_n_in,
   input  logic                           clear_pos,
   input  logic                           err_clear,
   output logic signed [POS_WIDTH-1:0]    position,
   output logic                           step_strobe,
   output logic                           step_dir,
   output logic        [PERIOD_WIDTH-1:0] step_period,
   output logic                           period_valid,
   output logic                           pulse_err,
   output logic                           setup_err
);

   localparam int WIDTH_W = $clog2(MIN_PULSE_CYCLES + 1);
   localparam int SETUP_W = $clog2(DIR_SETUP_CYCLES + 1);
   localparam logic [WIDTH_W-1:0]      WIDTH_MAX  = WIDTH_W'(MIN_PULSE_CYCLES);
   localparam logic [SETUP_W-1:0]      SETUP_MAX  = SETUP_W'(DIR_SETUP_CYCLES);
   localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;
   localparam logic signed [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

   // CLK_FREQ_HZ only documents the cycle counts; reject nonsensical sets.
   if (CLK_FREQ_HZ < 1 || MIN_PULSE_CYCLES < 1 || DIR_SETUP_CYCLES < 1) begin : g_bad_params
      $error("step_dir_decoder: parameters must be positive");
   end

   typedef enum logic {IDLE, HIGH} state_t;

   function automatic logic [PERIOD_WIDTH-1:0] sat_inc(input logic [PERIOD_WIDTH-1:0] v);
      return (v == PERIOD_MAX) ? v : v + PERIOD_WIDTH'(1);
   endfunction

   // Value the interval counter would hold had the rejected edge never
   // restarted it: pre-edge value plus cycles since, plus this cycle.
   function automatic logic [PERIOD_WIDTH-1:0] resume_interval(
      input logic [PERIOD_WIDTH-1:0] held,
      input logic [PERIOD_WIDTH-1:0] since
   );
      logic [PERIOD_WIDTH+1:0] sum;
      sum = {2'b00, held} + {2'b00, since} + (PERIOD_WIDTH+2)'(1);
      if (sum > {2'b00, PERIOD_MAX}) return PERIOD_MAX;
      return sum[PERIOD_WIDTH-1:0];
   endfunction

   logic step_p0, step_s, step_prev;
   logic dir_p0, dir_s;
   logic en_n_p0, en_n_s;
   logic [1:0] sync_fill;
   logic armed;

   state_t state_q, state_d;
   logic start, finish, accept, width_fail, setup_fail, restore;

   logic [WIDTH_W-1:0]      width_cnt;
   logic [SETUP_W-1:0]      dir_stable_cnt;
   logic                    cap_dir, cap_setup_ok;
   logic [PERIOD_WIDTH-1:0] interval_cnt, interval_hold;
   logic                    have_prior;

   // Stage p0 -> s: two-flop synchronisers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         step_p0   <= 1'b0;
         step_s    <= 1'b0;
         step_prev <= 1'b0;
         dir_p0    <= 1'b0;
         dir_s     <= 1'b0;
         en_n_p0   <= 1'b0;
         en_n_s    <= 1'b0;
         sync_fill <= 2'd0;
         armed     <= 1'b0;
      end else begin
         step_p0   <= step_in;
         step_s    <= step_p0;
         step_prev <= step_s;
         dir_p0    <= dir_in;
         dir_s     <= dir_p0;
         en_n_p0   <= enable_n_in;
         en_n_s    <= en_n_p0;
         if (sync_fill != 2'd2) sync_fill <= sync_fill + 2'd1;
         // The cleared chain looks like STEP low; only trust step_s once real
         // pin data has reached it, and require a genuine low before the
         // first edge so a pulse cut by reset is not counted on its tail.
         if (sync_fill == 2'd2 && !step_s) armed <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      start      = 1'b0;
      finish     = 1'b0;
      accept     = 1'b0;
      width_fail = 1'b0;
      setup_fail = 1'b0;
      case (state_q)
         IDLE: begin
            if (armed && step_s && !step_prev && !en_n_s) begin
               state_d = HIGH;
               start   = 1'b1;
            end
         end
         HIGH: begin
            if (!step_s) begin
               state_d = IDLE;
               finish  = 1'b1;
               if (!en_n_s) begin
                  width_fail = (width_cnt < WIDTH_MAX);
                  setup_fail = !cap_setup_ok;
                  accept     = !(width_cnt < WIDTH_MAX) && cap_setup_ok;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      restore = finish && !accept;
   end

   // Stage s -> outputs: pulse qualification, position and period
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         width_cnt      <= '0;
         dir_stable_cnt <= '0;
         cap_dir        <= 1'b0;
         cap_setup_ok   <= 1'b0;
         interval_cnt   <= '0;
         interval_hold  <= '0;
         have_prior     <= 1'b0;
         position       <= '0;
         step_strobe    <= 1'b0;
         step_dir       <= 1'b0;
         step_period    <= '0;
         period_valid   <= 1'b0;
         pulse_err      <= 1'b0;
         setup_err      <= 1'b0;
      end else begin
         // Cleared on the edge where dir_s takes its new value, so the count
         // equals the number of cycles dir_s has held its current level.
         if (dir_p0 != dir_s)                dir_stable_cnt <= '0;
         else if (dir_stable_cnt < SETUP_MAX) dir_stable_cnt <= dir_stable_cnt + SETUP_W'(1);

         if (start) begin
            width_cnt    <= WIDTH_W'(1);
            cap_dir      <= dir_s;
            cap_setup_ok <= (dir_stable_cnt >= SETUP_MAX);
         end else if (state_q == HIGH && step_s && width_cnt < WIDTH_MAX) begin
            width_cnt <= width_cnt + WIDTH_W'(1);
         end

         if (start) begin
            interval_hold <= interval_cnt;
            interval_cnt  <= PERIOD_WIDTH'(1);
         end else if (restore) begin
            interval_cnt  <= resume_interval(interval_hold, interval_cnt);
         end else begin
            interval_cnt  <= sat_inc(interval_cnt);
         end

         step_strobe <= accept;
         if (accept) begin
            step_dir   <= cap_dir;
            have_prior <= 1'b1;
            if (have_prior) begin
               step_period  <= interval_hold;
               period_valid <= 1'b1;
            end
         end

         if (clear_pos)   position <= '0;
         else if (accept) position <= cap_dir ? position - POS_ONE : position + POS_ONE;

         pulse_err <= (pulse_err && !err_clear) || width_fail;
         setup_err <= (setup_err && !err_clear) || setup_fail;
      end
   end

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed bench for step_dir_decoder: a table of pulse records followed by
// hand-written sequences for clear/strobe coincidence, wrap and reset.
module tb_step_dir_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n, step_in, dir_in, enable_n_in, clear_pos, err_clear;

   logic [31:0] position;
   logic        step_strobe, step_dir, period_valid, pulse_err, setup_err;
   logic [23:0] step_period;

   logic [3:0]  s_position;
   logic        s_step_strobe, s_step_dir, s_period_valid, s_pulse_err, s_setup_err;
   logic [23:0] s_step_period;

   step_dir_decoder dut (
      .clk(clk), .reset_n(reset_n), .step_in(step_in), .dir_in(dir_in),
      .enable_n_in(enable_n_in), .clear_pos(clear_pos), .err_clear(err_clear),
      .position(position), .step_strobe(step_strobe), .step_dir(step_dir),
      .step_period(step_period), .period_valid(period_valid),
      .pulse_err(pulse_err), .setup_err(setup_err)
   );

   // Narrow-position copy on the same pins, used to exercise wrap-around.
   step_dir_decoder #(.POS_WIDTH(4)) dut_small (
      .clk(clk), .reset_n(reset_n), .step_in(step_in), .dir_in(dir_in),
      .enable_n_in(enable_n_in), .clear_pos(clear_pos), .err_clear(err_clear),
      .position(s_position), .step_strobe(s_step_strobe), .step_dir(s_step_dir),
      .step_period(s_step_period), .period_valid(s_period_valid),
      .pulse_err(s_pulse_err), .setup_err(s_setup_err)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int strobe_cnt = 0;

   always @(negedge clk) if (step_strobe === 1'b1) strobe_cnt++;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic pulse(input int high, input int low);
      step_in = 1'b1;
      tick(high);
      step_in = 1'b0;
      tick(low);
   endtask

   typedef struct {
      bit          clr;
      bit          en_n;
      bit          dir;
      int          pre;
      int          high;
      int          low;
      logic [31:0] pos;
      int          dstb;
      bit          sdir;
      bit          perr;
      bit          serr;
      int          period;
      int          pv;
   } vec_t;

   vec_t tbl[19];

   initial begin
      int base;

      tbl[0]  = '{0,0,0, 0,50,50, 32'd1, 1,0,0,0, -1, 0};
      tbl[1]  = '{0,0,0, 0,50,50, 32'd2, 1,0,0,0, 100, 1};
      tbl[2]  = '{0,0,0, 0,50,50, 32'd3, 1,0,0,0, 100, 1};
      tbl[3]  = '{0,0,0, 0,50,50, 32'd4, 1,0,0,0, 100, 1};
      tbl[4]  = '{0,0,0, 0,50,50, 32'd5, 1,0,0,0, 100, 1};
      tbl[5]  = '{0,0,1,12,60,50, 32'd4, 1,1,0,0, 112, 1};
      tbl[6]  = '{0,0,1, 0,60,50, 32'd3, 1,1,0,0, 110, 1};
      tbl[7]  = '{0,0,1, 0,60,50, 32'd2, 1,1,0,0, 110, 1};
      tbl[8]  = '{0,0,1, 0,49,50, 32'd2, 0,1,1,0, -1, -1};
      tbl[9]  = '{1,0,1, 0, 0, 5, 32'd2, 0,1,0,0, -1, -1};
      tbl[10] = '{0,0,0, 5,50,50, 32'd2, 0,1,0,1, -1, -1};
      tbl[11] = '{1,0,1, 9,50,50, 32'd2, 0,1,0,1, -1, -1};
      tbl[12] = '{1,0,0,10,50,50, 32'd3, 1,0,0,0, -1, -1};
      tbl[13] = '{0,0,1, 3,30,50, 32'd3, 0,0,1,1, -1, -1};
      tbl[14] = '{1,0,1, 0, 0, 5, 32'd3, 0,0,0,0, -1, -1};
      tbl[15] = '{0,1,0,20,50,50, 32'd3, 0,0,0,0, -1, -1};
      tbl[16] = '{0,1,0, 0,50,50, 32'd3, 0,0,0,0, -1, -1};
      tbl[17] = '{0,1,0, 0,50,50, 32'd3, 0,0,0,0, -1, -1};
      tbl[18] = '{0,1,0, 0,20,50, 32'd3, 0,0,0,0, -1, -1};

      reset_n = 1'b0; step_in = 1'b0; dir_in = 1'b0; enable_n_in = 1'b0;
      clear_pos = 1'b0; err_clear = 1'b0;
      tick(3);
      check("rst position", position, 0);
      check("rst strobe", step_strobe, 0);
      check("rst period_valid", period_valid, 0);
      check("rst errors", {pulse_err, setup_err}, 0);
      reset_n = 1'b1;
      tick(20);

      for (int i = 0; i < 19; i++) begin
         base = strobe_cnt;
         enable_n_in = tbl[i].en_n;
         if (tbl[i].clr) begin
            err_clear = 1'b1;
            tick(1);
            err_clear = 1'b0;
         end
         dir_in = tbl[i].dir;
         tick(tbl[i].pre);
         if (tbl[i].high > 0) pulse(tbl[i].high, tbl[i].low);
         else tick(tbl[i].low);
         check($sformatf("v%0d position", i), position, tbl[i].pos);
         check($sformatf("v%0d small_position", i), s_position, tbl[i].pos[3:0]);
         check($sformatf("v%0d strobes", i), strobe_cnt - base, tbl[i].dstb);
         check($sformatf("v%0d step_dir", i), step_dir, tbl[i].sdir);
         check($sformatf("v%0d pulse_err", i), pulse_err, tbl[i].perr);
         check($sformatf("v%0d setup_err", i), setup_err, tbl[i].serr);
         if (tbl[i].period >= 0)
            check($sformatf("v%0d step_period", i), step_period, tbl[i].period);
         if (tbl[i].pv >= 0)
            check($sformatf("v%0d period_valid", i), period_valid, tbl[i].pv);
      end

      // Enable drops mid-pulse then returns high before the falling edge.
      base = strobe_cnt;
      step_in = 1'b1; tick(10);
      enable_n_in = 1'b0; tick(20);
      enable_n_in = 1'b1; tick(20);
      step_in = 1'b0; tick(50);
      check("en_mid strobes", strobe_cnt - base, 0);
      check("en_mid position", position, 3);
      check("en_mid errors", {pulse_err, setup_err}, 0);

      enable_n_in = 1'b0; tick(20);
      base = strobe_cnt;
      pulse(50, 50);
      check("reenable position", position, 4);
      check("reenable strobes", strobe_cnt - base, 1);

      // clear_pos lands on the very cycle the strobe is produced.
      step_in = 1'b1; tick(50);
      step_in = 1'b0; tick(2);
      check("latency strobe early", step_strobe, 0);
      clear_pos = 1'b1; tick(1);
      clear_pos = 1'b0;
      check("clr_coinc strobe", step_strobe, 1);
      check("clr_coinc position", position, 0);
      check("clr_coinc small_position", s_position, 0);
      tick(1);
      check("strobe one cycle", step_strobe, 0);
      tick(48);

      // 0 - 1 wraps to all ones.
      dir_in = 1'b1; tick(20);
      pulse(50, 50);
      check("wrap_neg position", position, 32'hFFFF_FFFF);
      check("wrap_neg small_position", s_position, 4'hF);
      check("wrap_neg step_dir", step_dir, 1);

      clear_pos = 1'b1; tick(1);
      clear_pos = 1'b0; tick(1);
      check("clear position", position, 0);

      // Max positive + 1 wraps to most negative on the 4-bit copy.
      dir_in = 1'b0; tick(20);
      for (int k = 0; k < 7; k++) pulse(50, 50);
      check("wrap_pos pre small_position", s_position, 4'h7);
      check("wrap_pos pre position", position, 7);
      pulse(50, 50);
      check("wrap_pos small_position", s_position, 4'h8);
      check("wrap_pos position", position, 8);

      pulse(20, 50);
      check("short pulse_err", pulse_err, 1);
      check("short period_valid", period_valid, 1);

      // Reset in the middle of a pulse.
      step_in = 1'b1; tick(25);
      reset_n = 1'b0; tick(2);
      check("midrst position", position, 0);
      check("midrst strobe", step_strobe, 0);
      check("midrst step_dir", step_dir, 0);
      check("midrst step_period", step_period, 0);
      check("midrst period_valid", period_valid, 0);
      check("midrst errors", {pulse_err, setup_err}, 0);
      check("midrst small outputs",
            {s_position, s_step_strobe, s_step_dir, s_step_period, s_period_valid,
             s_pulse_err, s_setup_err}, 0);
      reset_n = 1'b1;
      base = strobe_cnt;
      tick(23);
      step_in = 1'b0; tick(50);
      check("tail strobes", strobe_cnt - base, 0);
      check("tail position", position, 0);
      check("tail pulse_err", pulse_err, 0);
      pulse(50, 50);
      check("post_rst position", position, 1);
      check("post_rst strobes", strobe_cnt - base, 1);
      check("post_rst period_valid", period_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
